// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_unit_pkg : shared encodings for the fetch stage (PC select, NOP, flags)
// | Revision: 1.0
// +----------------------------------------------------------------------------+
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    PS_HOLD = 2'b00,
    PS_INC  = 2'b01,
    PS_REL  = 2'b10,
    PS_REG  = 2'b11
  } ps_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD = 32'hD503201F;

  // Bit positions inside the {V,C,N,Z} status word.
  localparam int STAT_V = 3;
  localparam int STAT_C = 2;
  localparam int STAT_N = 1;
  localparam int STAT_Z = 0;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_pc_next.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_next_logic : combinational next-PC selection and link-address adder
// | Revision: 1.0
// +----------------------------------------------------------------------------+
module pc_next_logic
  import fetch_unit_pkg::*;
(
  input  logic [63:0] pc,
  input  ps_e         ps,
  input  logic [63:0] k,
  input  logic [63:0] pc_in,
  input  logic        hold,
  output logic [63:0] pc_next,
  output logic [63:0] pc_plus4
);

  logic [63:0] pc_rel;

  assign pc_plus4 = pc + 64'd4;
  // k counts words; the shift drops its top bits, giving modulo-2^64 wrap.
  assign pc_rel   = pc + (k << 2);

  always_comb begin
    pc_next = pc;
    if (!hold) begin
      unique case (ps)
        PS_HOLD: pc_next = pc;
        PS_INC:  pc_next = pc_plus4;
        PS_REL:  pc_next = pc_rel;
        PS_REG:  pc_next = pc_in;
        default: pc_next = pc;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_unit : PC, instruction register and status register with ROM fetch
// | Revision: 1.0
// +----------------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned MAX_WAIT = 8,
  parameter logic [31:0] NOP_WORD = fetch_unit_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ps,
  input  logic [63:0] k,
  input  logic [63:0] pc_in,
  input  logic        ir_load,
  input  logic        stat_en,
  input  logic [3:0]  status_in,
  output logic [63:0] rom_addr,
  output logic        rom_req,
  input  logic [31:0] rom_data,
  input  logic        rom_ack,
  output logic [31:0] i,
  output logic        ir_valid,
  output logic [3:0]  status,
  output logic [63:0] pc,
  output logic [63:0] pc_plus4,
  output logic        stall,
  output logic        fetch_err
);

  import fetch_unit_pkg::*;

  localparam int              CNT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  fetch_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      fetch_addr_q, fetch_addr_d;
  logic [63:0]      pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic             ir_valid_q, ir_valid_d;
  logic [3:0]       status_q, status_d;
  logic             rom_req_q, rom_req_d;
  logic             fetch_err_q, fetch_err_d;

  // The PC must not move while a fetch is being launched or is in flight.
  assign stall = (state_q == ST_WAIT) || ir_load;

  pc_next_logic u_pc_next (
    .pc       (pc_q),
    .ps       (ps_e'(ps)),
    .k        (k),
    .pc_in    (pc_in),
    .hold     (stall),
    .pc_next  (pc_d),
    .pc_plus4 (pc_plus4)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fetch_addr_d = fetch_addr_q;
    ir_d         = ir_q;
    ir_valid_d   = ir_valid_q;
    rom_req_d    = rom_req_q;
    fetch_err_d  = fetch_err_q;
    status_d     = stat_en ? status_in : status_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ir_load) begin
          state_d      = ST_WAIT;
          cnt_d        = '0;
          fetch_addr_d = pc_q;
          rom_req_d    = 1'b1;
          ir_valid_d   = 1'b0;
        end
      end
      ST_WAIT: begin
        if (rom_ack) begin
          state_d     = ST_IDLE;
          ir_d        = rom_data;
          ir_valid_d  = 1'b1;
          fetch_err_d = 1'b0;
          rom_req_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          ir_d        = NOP_WORD;
          ir_valid_d  = 1'b1;
          fetch_err_d = 1'b1;
          rom_req_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      fetch_addr_q <= '0;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      ir_valid_q   <= 1'b0;
      status_q     <= '0;
      rom_req_q    <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fetch_addr_q <= fetch_addr_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      ir_valid_q   <= ir_valid_d;
      status_q     <= status_d;
      rom_req_q    <= rom_req_d;
      fetch_err_q  <= fetch_err_d;
    end
  end

  assign rom_addr  = rom_req_q ? fetch_addr_q : pc_q;
  assign rom_req   = rom_req_q;
  assign i         = ir_q;
  assign ir_valid  = ir_valid_q;
  assign status    = status_q;
  assign pc        = pc_q;
  assign fetch_err = fetch_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_unit : directed + randomized bench for fetch_unit against a model
// | Revision: 1.0
// +----------------------------------------------------------------------------+
module tb_fetch_unit;

  localparam int          MAXW = 8;
  localparam logic [31:0] NOP  = 32'hD503201F;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ps;
  logic [63:0] k, pc_in;
  logic        ir_load, stat_en;
  logic [3:0]  status_in;
  logic [63:0] rom_addr;
  logic        rom_req;
  logic [31:0] rom_data;
  logic        rom_ack;
  logic [31:0] i;
  logic        ir_valid;
  logic [3:0]  status;
  logic [63:0] pc, pc_plus4;
  logic        stall, fetch_err;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(64'h0), .MAX_WAIT(MAXW), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .ps(ps), .k(k), .pc_in(pc_in), .ir_load(ir_load),
    .stat_en(stat_en), .status_in(status_in), .rom_addr(rom_addr), .rom_req(rom_req),
    .rom_data(rom_data), .rom_ack(rom_ack), .i(i), .ir_valid(ir_valid),
    .status(status), .pc(pc), .pc_plus4(pc_plus4), .stall(stall), .fetch_err(fetch_err)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: one outstanding fetch, counted in elapsed unanswered cycles.
  logic [63:0] m_pc, m_addr;
  logic [31:0] m_i;
  logic [3:0]  m_status;
  logic        m_valid, m_err, m_busy;
  int          m_waited;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 64'h0; m_addr = 64'h0; m_i = 32'h0; m_status = 4'h0;
    m_valid = 1'b0; m_err = 1'b0; m_busy = 1'b0; m_waited = 0;
  endtask

  task automatic compare_outputs();
    chk("pc",        pc,        m_pc);
    chk("pc_plus4",  pc_plus4,  m_pc + 64'd4);
    chk("stall",     64'(stall), 64'(m_busy || ir_load));
    chk("rom_req",   64'(rom_req), 64'(m_busy));
    chk("rom_addr",  rom_addr,  m_busy ? m_addr : m_pc);
    chk("i",         64'(i),    64'(m_i));
    chk("ir_valid",  64'(ir_valid), 64'(m_valid));
    chk("status",    64'(status), 64'(m_status));
    chk("fetch_err", 64'(fetch_err), 64'(m_err));
  endtask

  task automatic model_update();
    logic hold;
    hold = m_busy || ir_load;
    if (m_busy) begin
      if (rom_ack) begin
        m_i = rom_data; m_valid = 1'b1; m_err = 1'b0; m_busy = 1'b0;
      end else begin
        m_waited++;
        if (m_waited == MAXW) begin
          m_i = NOP; m_valid = 1'b1; m_err = 1'b1; m_busy = 1'b0;
        end
      end
    end else if (ir_load) begin
      m_busy = 1'b1; m_waited = 0; m_addr = m_pc; m_valid = 1'b0;
    end
    if (!hold) begin
      case (ps)
        2'd1:    m_pc = m_pc + 64'd4;
        2'd2:    m_pc = m_pc + k * 64'd4;
        2'd3:    m_pc = pc_in;
        default: m_pc = m_pc;
      endcase
    end
    if (stat_en) m_status = status_in;
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    rst = 1'b1; ps = 2'd0; k = '0; pc_in = '0; ir_load = 1'b0; stat_en = 1'b0;
    status_in = '0; rom_data = '0; rom_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset pc",       pc, 64'h0);
    chk("reset i",        64'(i), 64'h0);
    chk("reset ir_valid", 64'(ir_valid), 64'h0);
    chk("reset status",   64'(status), 64'h0);
    chk("reset rom_req",  64'(rom_req), 64'h0);
    chk("reset stall",    64'(stall), 64'h0);
    chk("reset err",      64'(fetch_err), 64'h0);
    rst = 1'b0;

    // Basic fetch, ack on the second WAIT cycle.
    ir_load = 1'b1; step();
    chk("fetch rom_req", 64'(rom_req), 64'h1);
    chk("fetch rom_addr", rom_addr, 64'h0);
    ir_load = 1'b0; step();
    rom_ack = 1'b1; rom_data = 32'h91000421; step();
    chk("fetch i", 64'(i), 64'h91000421);
    chk("fetch ir_valid", 64'(ir_valid), 64'h1);
    chk("fetch rom_req done", 64'(rom_req), 64'h0);
    rom_ack = 1'b0;

    // Sequential increment.
    ps = 2'd1;
    step(); chk("inc pc 4", pc, 64'd4);
    step(); chk("inc pc 8", pc, 64'd8);
    step(); chk("inc pc 12", pc, 64'd12);
    chk("inc pc_plus4", pc_plus4, 64'd16);

    // PC-relative backwards branch.
    ps = 2'd3; pc_in = 64'h100; step();
    ps = 2'd2; k = 64'hFFFF_FFFF_FFFF_FFFE; step();
    chk("rel pc", pc, 64'hF8);

    // Register jump concurrent with ir_load is suppressed by stall.
    ps = 2'd3; pc_in = 64'h2000; ir_load = 1'b1; step();
    chk("br hold pc", pc, 64'hF8);
    chk("br fetch addr", rom_addr, 64'hF8);
    ir_load = 1'b0; ps = 2'd0; rom_ack = 1'b1; rom_data = 32'h8B020020; step();
    chk("br ir_valid", 64'(ir_valid), 64'h1);
    rom_ack = 1'b0; ps = 2'd3; step();
    chk("br pc", pc, 64'h2000);
    ps = 2'd0;

    // Timeout path, then a good fetch clears the sticky error.
    ir_load = 1'b1; step();
    ir_load = 1'b0;
    repeat (MAXW - 1) step();
    chk("to still waiting", 64'(rom_req), 64'h1);
    step();
    chk("to i", 64'(i), 64'(NOP));
    chk("to err", 64'(fetch_err), 64'h1);
    chk("to rom_req", 64'(rom_req), 64'h0);
    ir_load = 1'b1; step();
    ir_load = 1'b0; rom_ack = 1'b1; rom_data = 32'hAA55AA55; step();
    chk("to err cleared", 64'(fetch_err), 64'h0);
    rom_ack = 1'b0;

    // Status register hold, then asynchronous reset during WAIT.
    stat_en = 1'b1; status_in = 4'b1001; step();
    stat_en = 1'b0; status_in = 4'b0110; step();
    chk("status hold", 64'(status), 64'h9);
    ir_load = 1'b1; step();
    ir_load = 1'b0; step();
    rst = 1'b1; #1;
    chk("rst rom_req", 64'(rom_req), 64'h0);
    chk("rst status", 64'(status), 64'h0);
    chk("rst pc", pc, 64'h0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    rom_ack = 1'b1; rom_data = 32'hDEADBEEF; step();
    rom_ack = 1'b0; step();

    // Randomized traffic with random ROM latency, including stale acks.
    for (int n = 0; n < 3000; n++) begin
      int kk;
      ps        = 2'($urandom_range(0, 3));
      kk        = int'($urandom_range(0, 63)) - 32;
      k         = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : {{32{kk[31]}}, kk};
      pc_in     = {$urandom, $urandom};
      ir_load   = ($urandom_range(0, 9) < 3);
      stat_en   = 1'($urandom_range(0, 1));
      status_in = 4'($urandom_range(0, 15));
      rom_ack   = ($urandom_range(0, 3) == 0);
      rom_data  = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
